// File: rtl/io_gpio_bank.sv
// io_gpio_bank: IO-mapped GPIO bank with synchronised inputs, rising-edge capture, masked irq.
// Define IO_TIMER_EN to add the prescaled 16-bit TIMER register at BASE+5.
module io_gpio_bank #(
  parameter int          GPIO_W      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [5:0]  BASE        = 6'd8,
  parameter int          TICK_DIV    = 12000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [5:0]        mem_addr,
  input  logic [15:0]       dout,
  output logic [15:0]       io_din,
  output logic              io_sel,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);
  logic              r_io_rd, r_io_wr;
  logic [15:0]       r_dout;
  logic [5:0]        r_io_addr;
  logic [GPIO_W-1:0] r_out, r_oe, r_edge, r_mask, r_prev;
  logic [GPIO_W-1:0] r_sync [SYNC_STAGES];
  logic              r_irq;
  logic [6:0]        w_off;
  logic              w_we;
  logic [GPIO_W-1:0] w_wd, w_in, w_rise, w_clr;
  logic [15:0]       w_timer;
  logic              w_unused;
  // 7-bit difference so addresses below BASE go negative instead of wrapping into range
  assign w_off    = {1'b0, r_io_addr} - {1'b0, BASE};
  assign io_sel   = w_off <= 7'd5;
  assign w_we     = r_io_wr & io_sel;
  assign w_wd     = r_dout[GPIO_W-1:0];
  assign w_in     = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_in & ~r_prev;
  assign w_clr    = (w_we && w_off[2:0] == 3'd3) ? w_wd : '0;
  assign gpio_out = r_out;
  assign gpio_oe  = r_oe;
  assign irq      = r_irq;
  assign w_unused = ^{r_io_rd, r_dout};
  assign io_din   = !io_sel ? 16'h0 :
                    w_off[2:0] == 3'd0 ? 16'(r_out) :
                    w_off[2:0] == 3'd1 ? 16'(r_oe) :
                    w_off[2:0] == 3'd2 ? 16'(w_in) :
                    w_off[2:0] == 3'd3 ? 16'(r_edge) :
                    w_off[2:0] == 3'd4 ? 16'(r_mask) : w_timer;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_io_rd   <= 1'b0;
      r_io_wr   <= 1'b0;
      r_dout    <= '0;
      r_io_addr <= '0;
      r_out     <= '0;
      r_oe      <= '0;
      r_edge    <= '0;
      r_mask    <= '0;
      r_prev    <= '0;
      r_irq     <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_io_rd <= io_rd;
      r_io_wr <= io_wr;
      r_dout  <= dout;
      if (io_rd || io_wr) r_io_addr <= mem_addr;
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_in;
      // a coincident rising edge beats the write-1-to-clear
      r_edge <= (r_edge & ~w_clr) | w_rise;
      r_irq  <= |(r_edge & r_mask);
      if (w_we && w_off[2:0] == 3'd0) r_out  <= w_wd;
      if (w_we && w_off[2:0] == 3'd1) r_oe   <= w_wd;
      if (w_we && w_off[2:0] == 3'd4) r_mask <= w_wd;
    end
  end
`ifdef IO_TIMER_EN
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_timer;
  logic          w_tick;
  assign w_tick  = r_pre == PW'(TICK_DIV - 1);
  assign w_timer = r_timer;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_timer <= '0;
    end else if (w_we && w_off[2:0] == 3'd5) begin
      r_pre   <= '0;
      r_timer <= r_dout;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_timer <= r_timer + 16'd1;
    end
  end
`else
  assign w_timer = 16'h0;
`endif
endmodule

// File: tb/tb_io_gpio_bank.sv
// tb_io_gpio_bank: directed checks of io_gpio_bank with BASE=8, GPIO_W=8, TICK_DIV=4.
module tb_io_gpio_bank;
  logic        clk = 1'b0;
  logic        reset, io_rd, io_wr;
  logic [5:0]  mem_addr;
  logic [15:0] dout, io_din;
  logic        io_sel, irq;
  logic [7:0]  gpio_in, gpio_out, gpio_oe;
  int          tests = 0, fails = 0;
  io_gpio_bank #(.GPIO_W(8), .SYNC_STAGES(2), .BASE(6'd8), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .mem_addr(mem_addr),
    .dout(dout), .io_din(io_din), .io_sel(io_sel), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    io_wr = 1'b1; mem_addr = a; dout = d;
    @(negedge clk);
    io_wr = 1'b0;
    @(negedge clk);
  endtask
  task automatic rd(input logic [5:0] a);
    @(negedge clk);
    io_rd = 1'b1; mem_addr = a;
    @(negedge clk);
    io_rd = 1'b0;
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  initial begin
    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; mem_addr = '0; dout = '0; gpio_in = '0;
    step(3);
    chk("rst_out", 16'(gpio_out), 16'h0);
    chk("rst_oe", 16'(gpio_oe), 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    chk("rst_sel", 16'(io_sel), 16'h0);
    reset = 1'b0;
    step(1);
    chk("post_rst_out", 16'(gpio_out), 16'h0);
    chk("post_rst_sel", 16'(io_sel), 16'h0);
    io_wr = 1'b1; mem_addr = 6'd8; dout = 16'h00A5;
    step(1);
    io_wr = 1'b0;
    chk("out_one_edge", 16'(gpio_out), 16'h0);
    step(1);
    chk("out_two_edges", 16'(gpio_out), 16'h00A5);
    rd(6'd8);
    chk("rd_out", io_din, 16'h00A5);
    chk("sel_in_range", 16'(io_sel), 16'h1);
    wr(6'd9, 16'h0F0F);
    chk("oe_trunc", 16'(gpio_oe), 16'h000F);
    rd(6'd9);
    chk("rd_oe", io_din, 16'h000F);
    wr(6'd12, 16'h0008);
    rd(6'd12);
    chk("rd_mask", io_din, 16'h0008);
    chk("irq_idle", 16'(irq), 16'h0);
    rd(6'd11);
    chk("edge_idle", io_din, 16'h0);
    gpio_in = 8'h08;
    step(2);
    chk("edge_two_edges", io_din, 16'h0);
    step(1);
    chk("edge_three_edges", io_din, 16'h0008);
    chk("irq_not_yet", 16'(irq), 16'h0);
    step(1);
    chk("irq_set", 16'(irq), 16'h1);
    rd(6'd10);
    chk("rd_in", io_din, 16'h0008);
    wr(6'd11, 16'h0008);
    chk("edge_w1c", io_din, 16'h0);
    step(1);
    chk("irq_cleared", 16'(irq), 16'h0);
    gpio_in = 8'h00;
    step(4);
    gpio_in = 8'h08;
    step(1);
    io_wr = 1'b1; mem_addr = 6'd11; dout = 16'h0008;
    step(1);
    io_wr = 1'b0;
    step(1);
    chk("set_beats_clear", io_din, 16'h0008);
    wr(6'd11, 16'h0008);
    chk("edge_cleared_again", io_din, 16'h0);
    gpio_in = 8'h00;
    step(3);
    @(negedge clk);
    io_wr = 1'b1; mem_addr = 6'd8; dout = 16'h003C;
    @(negedge clk);
    io_wr = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wins_out", 16'(gpio_out), 16'h0);
    step(2);
    chk("rst_drop_write", 16'(gpio_out), 16'h0);
    chk("rst_clr_oe", 16'(gpio_oe), 16'h0);
    rd(6'd40);
    chk("rd_far", io_din, 16'h0);
    chk("sel_far", 16'(io_sel), 16'h0);
    rd(6'd14);
    chk("rd_off6", io_din, 16'h0);
    chk("sel_off6", 16'(io_sel), 16'h0);
    rd(6'd7);
    chk("sel_below", 16'(io_sel), 16'h0);
`ifdef IO_TIMER_EN
    wr(6'd13, 16'hFFFE);
    chk("tmr_load", io_din, 16'hFFFE);
    step(3);
    chk("tmr_3cyc", io_din, 16'hFFFE);
    step(1);
    chk("tmr_4cyc", io_din, 16'hFFFF);
    step(4);
    chk("tmr_wrap", io_din, 16'h0000);
`else
    wr(6'd13, 16'h1234);
    chk("tmr_absent", io_din, 16'h0);
    chk("tmr_sel", 16'(io_sel), 16'h1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
